// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: data-hazard unit for the five-stage RISC-V core.
// Drives the EX operand forwarding selects, detects load-use hazards and holds
// decode for LOAD_USE_LAT bubble cycles, and optionally tracks outstanding
// long-latency writebacks in a register scoreboard.
// Optional feature: define HFU_SCOREBOARD_EN to build the scoreboard; without
// it sb_count/sb_full are tied to zero and the lsu_* inputs are ignored.
module hazard_forward_unit #(
    parameter  int AW           = 5,
    parameter  int NUM_SRC      = 2,
    parameter  int NUM_STAGES   = 2,
    parameter  int LOAD_USE_LAT = 1,
    parameter  int MAX_OUT      = 4,
    localparam int SW           = $clog2(NUM_STAGES + 1),
    localparam int CW           = $clog2(MAX_OUT + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC*AW-1:0]   ex_rs,
    input  logic [NUM_STAGES*AW-1:0] fwd_rd,
    input  logic [NUM_STAGES-1:0]   fwd_regwrite,
    input  logic [NUM_SRC*AW-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]      id_rs_used,
    input  logic                    ex_is_load,
    input  logic                    ex_regwrite,
    input  logic [AW-1:0]           ex_rd,
    input  logic                    flush,
    input  logic                    lsu_issue,
    input  logic                    lsu_done,
    input  logic [AW-1:0]           lsu_issue_rd,
    input  logic [AW-1:0]           lsu_done_rd,
    output logic [NUM_SRC*SW-1:0]   fwd_sel,
    output logic                    stall,
    output logic                    bubble,
    output logic                    sb_full,
    output logic [CW-1:0]           sb_count
);

    localparam int CNTW = $clog2(LOAD_USE_LAT + 1);

    typedef enum logic {
        IDLE,
        HOLD
    } lu_state_t;

    lu_state_t       state, state_next;
    logic [CNTW-1:0] cnt, cnt_next;
    logic            lu_stall;
    logic            id_reads_ex_rd;
    logic            ld_haz;
    logic            sb_haz;

    // Forwarding select per operand: scan oldest to youngest so the youngest match is kept.
    always_comb begin
        fwd_sel = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = NUM_STAGES; k >= 1; k--) begin
                // NOTE: blocking assignments in combinational logic, so a later
                // (younger) match simply overwrites an older one within the pass.
                if (fwd_regwrite[k-1] &&
                    (fwd_rd[(k-1)*AW +: AW] != '0) &&
                    (fwd_rd[(k-1)*AW +: AW] == ex_rs[s*AW +: AW])) begin
                    fwd_sel[s*SW +: SW] = SW'(k);
                end
            end
        end
    end

    // Does any used ID operand read the register the EX instruction writes?
    always_comb begin
        id_reads_ex_rd = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (id_rs_used[s] && (id_rs[s*AW +: AW] == ex_rd)) begin
                id_reads_ex_rd = 1'b1;
            end
        end
    end

    assign ld_haz = ex_is_load & ex_regwrite & (ex_rd != '0) & id_reads_ex_rd;

    // Load-use FSM state and bubble counter register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all sequential state, so every
        // flop samples the pre-edge value regardless of statement order.
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Load-use next-state and stall decode; flush overrides the next state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        cnt_next   = cnt;
        lu_stall   = 1'b0;
        case (state)
            IDLE: begin
                if (ld_haz) begin
                    lu_stall = 1'b1;
                    if (LOAD_USE_LAT > 1) begin
                        state_next = HOLD;
                        cnt_next   = CNTW'(LOAD_USE_LAT - 1);
                    end
                end
            end
            HOLD: begin
                lu_stall = 1'b1;
                cnt_next = cnt - CNTW'(1);
                if (cnt == CNTW'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end
    end

`ifdef HFU_SCOREBOARD_EN
    logic [(1<<AW)-1:0] pending;
    logic [CW-1:0]      count;
    logic               issue_v;

    // Writes to x0 never become outstanding.
    assign issue_v = lsu_issue && (lsu_issue_rd != '0);

    // Pending bits and outstanding count; issue is applied after done so it wins on the same rd.
    always_ff @(posedge clk) begin
        // NOTE: pending is a small flop array, not a RAM macro, so it is reset
        // explicitly; stale bits would stall decode forever after reset.
        if (rst) begin
            pending <= '0;
            count   <= '0;
        end else begin
            if (lsu_done) begin
                pending[lsu_done_rd] <= 1'b0;
            end
            if (issue_v) begin
                pending[lsu_issue_rd] <= 1'b1;
            end
            if (issue_v && !lsu_done) begin
                if (count != CW'(MAX_OUT)) begin
                    count <= count + CW'(1);
                end
            end else if (lsu_done && !issue_v) begin
                if (count != '0) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    // Protocol checks: no issue into a full scoreboard, no completion with nothing outstanding.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(issue_v && !lsu_done && (count == CW'(MAX_OUT))));
            assert (!(lsu_done && (count == '0)));
        end
    end

    // Scoreboard hazard from the registered pending bits only (no same-cycle done bypass).
    always_comb begin
        sb_haz = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (id_rs_used[s] && pending[id_rs[s*AW +: AW]]) begin
                sb_haz = 1'b1;
            end
        end
    end

    assign sb_count = count;
    assign sb_full  = (count == CW'(MAX_OUT));
`else
    logic unused_lsu;

    assign unused_lsu = ^{lsu_issue, lsu_done, lsu_issue_rd, lsu_done_rd};
    assign sb_haz     = 1'b0;
    assign sb_count   = '0;
    assign sb_full    = 1'b0;
`endif

    assign stall  = lu_stall | sb_haz;
    assign bubble = stall;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed-vector bench for hazard_forward_unit.
// Main DUT uses LOAD_USE_LAT=3, MAX_OUT=2; a second instance with
// LOAD_USE_LAT=1 shares the inputs. Scoreboard expectations depend on
// whether HFU_SCOREBOARD_EN is defined.
module tb_hazard_forward_unit;

`ifdef HFU_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] ex_rs;
    logic [9:0] fwd_rd;
    logic [1:0] fwd_regwrite;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic       ex_is_load;
    logic       ex_regwrite;
    logic [4:0] ex_rd;
    logic       flush;
    logic       lsu_issue;
    logic       lsu_done;
    logic [4:0] lsu_issue_rd;
    logic [4:0] lsu_done_rd;

    logic [3:0] fwd_sel;
    logic       stall;
    logic       bubble;
    logic       sb_full;
    logic [1:0] sb_count;

    logic [3:0] fwd_sel_1;
    logic       stall_1;
    logic       bubble_1;
    logic       sb_full_1;
    logic [1:0] sb_count_1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .AW(5), .NUM_SRC(2), .NUM_STAGES(2), .LOAD_USE_LAT(3), .MAX_OUT(2)
    ) u_dut (
        .clk(clk), .rst(rst), .ex_rs(ex_rs), .fwd_rd(fwd_rd),
        .fwd_regwrite(fwd_regwrite), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_is_load(ex_is_load), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
        .flush(flush), .lsu_issue(lsu_issue), .lsu_done(lsu_done),
        .lsu_issue_rd(lsu_issue_rd), .lsu_done_rd(lsu_done_rd),
        .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble),
        .sb_full(sb_full), .sb_count(sb_count)
    );

    hazard_forward_unit #(
        .AW(5), .NUM_SRC(2), .NUM_STAGES(2), .LOAD_USE_LAT(1), .MAX_OUT(2)
    ) u_dut_lat1 (
        .clk(clk), .rst(rst), .ex_rs(ex_rs), .fwd_rd(fwd_rd),
        .fwd_regwrite(fwd_regwrite), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_is_load(ex_is_load), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
        .flush(flush), .lsu_issue(lsu_issue), .lsu_done(lsu_done),
        .lsu_issue_rd(lsu_issue_rd), .lsu_done_rd(lsu_done_rd),
        .fwd_sel(fwd_sel_1), .stall(stall_1), .bubble(bubble_1),
        .sb_full(sb_full_1), .sb_count(sb_count_1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        ex_rs        = '0;
        fwd_rd       = '0;
        fwd_regwrite = '0;
        id_rs        = '0;
        id_rs_used   = '0;
        ex_is_load   = 1'b0;
        ex_regwrite  = 1'b0;
        ex_rd        = '0;
        flush        = 1'b0;
        lsu_issue    = 1'b0;
        lsu_done     = 1'b0;
        lsu_issue_rd = '0;
        lsu_done_rd  = '0;
        tick();
        tick();
        #2;
        check("rst_stall", stall, 0);
        check("rst_bubble", bubble, 0);
        check("rst_sb_count", sb_count, 0);
        check("rst_sb_full", sb_full, 0);

        // Forwarding priority
        tick();
        rst          = 1'b0;
        ex_rs        = {5'd0, 5'd5};
        fwd_rd       = {5'd5, 5'd5};
        fwd_regwrite = 2'b11;
        #2;
        check("fwd_both_stages", fwd_sel[1:0], 1);
        check("fwd_op1_none", fwd_sel[3:2], 0);
        fwd_regwrite = 2'b10;
        #2;
        check("fwd_stage1_only", fwd_sel[1:0], 2);
        fwd_rd       = {5'd0, 5'd0};
        fwd_regwrite = 2'b11;
        #2;
        check("fwd_x0", fwd_sel[1:0], 0);
        ex_rs  = {5'd3, 5'd5};
        fwd_rd = {5'd3, 5'd5};
        #2;
        check("fwd_split_op0", fwd_sel[1:0], 1);
        check("fwd_split_op1", fwd_sel[3:2], 2);

        // Load-use, three bubbles; the bubble removes the load from EX
        tick();
        fwd_regwrite = 2'b00;
        #2;
        check("fwd_no_write", fwd_sel, 0);
        tick();
        ex_is_load  = 1'b1;
        ex_regwrite = 1'b1;
        ex_rd       = 5'd7;
        id_rs       = {5'd7, 5'd2};
        id_rs_used  = 2'b10;
        #2;
        check("lu_c1_stall", stall, 1);
        check("lu_c1_bubble", bubble, 1);
        check("lu_c1_lat1_stall", stall_1, 1);
        tick();
        ex_is_load = 1'b0;
        #2;
        check("lu_c2_stall", stall, 1);
        check("lu_c2_lat1_stall", stall_1, 0);
        tick();
        #2;
        check("lu_c3_stall", stall, 1);
        check("lu_c3_bubble", bubble, 1);
        tick();
        #2;
        check("lu_c4_stall", stall, 0);
        check("lu_c4_bubble", bubble, 0);

        // Load present but no used operand matches
        ex_is_load = 1'b1;
        id_rs_used = 2'b00;
        #2;
        check("lu_unused_op", stall, 0);
        id_rs_used = 2'b01;
        #2;
        check("lu_other_op", stall, 0);
        ex_rd      = 5'd0;
        id_rs      = {5'd0, 5'd2};
        id_rs_used = 2'b10;
        #2;
        check("lu_rd_x0", stall, 0);
        ex_is_load = 1'b0;

        // Flush in the second stall cycle
        tick();
        ex_is_load = 1'b1;
        ex_rd      = 5'd7;
        id_rs      = {5'd7, 5'd2};
        id_rs_used = 2'b10;
        #2;
        check("fl_c1_stall", stall, 1);
        tick();
        ex_is_load = 1'b0;
        flush      = 1'b1;
        #2;
        check("fl_c2_stall", stall, 1);
        tick();
        flush = 1'b0;
        #2;
        check("fl_c3_stall", stall, 0);

        // Flush on the hazard cycle itself: stall now, no HOLD afterwards
        ex_is_load = 1'b1;
        flush      = 1'b1;
        #2;
        check("fl_idle_stall", stall, 1);
        tick();
        ex_is_load = 1'b0;
        flush      = 1'b0;
        #2;
        check("fl_idle_next", stall, 0);

        // Scoreboard issue / done of x9
        tick();
        id_rs_used   = 2'b00;
        lsu_issue    = 1'b1;
        lsu_issue_rd = 5'd9;
        #2;
        check("sb_issue_cycle_count", sb_count, 0);
        tick();
        lsu_issue  = 1'b0;
        id_rs      = {5'd0, 5'd9};
        id_rs_used = 2'b01;
        #2;
        check("sb_after_issue_count", sb_count, SB ? 1 : 0);
        check("sb_after_issue_stall", stall, SB ? 1 : 0);
        lsu_done    = 1'b1;
        lsu_done_rd = 5'd9;
        #2;
        check("sb_done_no_bypass", stall, SB ? 1 : 0);
        tick();
        lsu_done = 1'b0;
        #2;
        check("sb_after_done_count", sb_count, 0);
        check("sb_after_done_stall", stall, 0);

        // Fill to MAX_OUT=2, then issue + done together
        id_rs_used   = 2'b00;
        lsu_issue    = 1'b1;
        lsu_issue_rd = 5'd3;
        tick();
        lsu_issue_rd = 5'd4;
        tick();
        lsu_issue = 1'b0;
        #2;
        check("sb_fill_count", sb_count, SB ? 2 : 0);
        check("sb_fill_full", sb_full, SB ? 1 : 0);
        lsu_issue    = 1'b1;
        lsu_issue_rd = 5'd6;
        lsu_done     = 1'b1;
        lsu_done_rd  = 5'd3;
        tick();
        lsu_issue = 1'b0;
        lsu_done  = 1'b0;
        #2;
        check("sb_swap_count", sb_count, SB ? 2 : 0);
        check("sb_swap_full", sb_full, SB ? 1 : 0);
        id_rs      = {5'd6, 5'd3};
        id_rs_used = 2'b01;
        #2;
        check("sb_retired_x3", stall, 0);
        id_rs_used = 2'b10;
        #2;
        check("sb_pending_x6", stall, SB ? 1 : 0);

        // Reset in the middle of HOLD
        tick();
        id_rs_used  = 2'b00;
        ex_is_load  = 1'b1;
        ex_rd       = 5'd7;
        id_rs       = {5'd7, 5'd2};
        id_rs_used  = 2'b10;
        #2;
        check("rs_c1_stall", stall, 1);
        tick();
        ex_is_load = 1'b0;
        rst        = 1'b1;
        #2;
        check("rs_hold_stall", stall, 1);
        tick();
        rst = 1'b0;
        #2;
        check("rs_after_stall", stall, 0);
        check("rs_after_count", sb_count, 0);
        check("rs_after_full", sb_full, 0);
        id_rs      = {5'd6, 5'd3};
        id_rs_used = 2'b10;
        #2;
        check("rs_pending_cleared", stall, 0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
